argmin_reduce: RTL and testbench
================================

// Module: argmin_reduce
// PURPOSE
//  Streaming arg-min reducer that sits directly in front of the min stage.
//  - Accepts one vector of floating-point values per frame (ready/valid, last-tagged).
//  - Feeds each new element against the running minimum into a min instance.
//  - Returns the minimum value, its element index and the frame length.
//  - Used for nearest-neighbour/lowest-cost selection.
// PARAMETERS
//  BITS       16      element width (16 half, 32 single)
//  PRECISION  "HALF"  passed to min; "HALF" or "SINGLE"
//  MAX_LEN    256     max elements per frame; frame force-terminated at this count
//  IDX_W      $clog2(MAX_LEN)  width of index; length port is IDX_W+1
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rstn       in   1        reset, asynchronous, active-low
//  in_valid   in   1        in_data/in_last valid
//  in_ready   out  1        element accepted when in_valid & in_ready
//  in_data    in   BITS     floating-point element
//  in_last    in   1        final element of frame
//  out_valid  out  1        result valid, held until out_ready
//  out_ready  in   1        downstream accepts result
//  out_data   out  BITS     minimum value of frame
//  out_index  out  IDX_W    index (0-based) of minimum element
//  out_len    out  IDX_W+1  number of elements consumed in frame
//  out_trunc  out  1        frame ended by MAX_LEN, not in_last
// BEHAVIOUR
//  Reset state (async on rstn low):
//   - FSM=IDLE; out_valid, out_data, out_index, out_len, out_trunc = 0.
//   - Internal count/min/index = 0.
//   - in_ready=1 once rstn high.
//  FSM states IDLE, ACCUM, WAIT, DONE; in_ready = (state==IDLE || state==ACCUM).
//  IDLE, on accept:
//   - cur_min=in_data, cur_idx=0, cnt=1; min instance not invoked.
//   - Next state DONE if in_last or MAX_LEN==1, else ACCUM.
//  ACCUM, on accept:
//   - One-cycle min in_valid pulse with a=cur_min, b=in_data.
//   - pend_idx=cnt; pend_last=in_last | (cnt==MAX_LEN-1); cnt++.
//   - Next state WAIT.
//  WAIT:
//   - in_ready=0; wait for min out_valid (any latency L>=1).
//   - On min out_valid: if b_min, cur_min=c and cur_idx=pend_idx; otherwise unchanged.
//   - Next state DONE if pend_last, else ACCUM.
//  min contract:
//   - b_min=1 only when b strictly less than a; ties keep a, so the earliest index wins.
//   - NaN/±0 ordering is whatever min defines; not altered here.
//  DONE:
//   - Registered out_valid=1; out_data=cur_min, out_index=cur_idx, out_len=cnt.
//   - out_trunc=1 iff the frame hit MAX_LEN without in_last on that element.
//   - Outputs stable while out_ready=0.
//   - On out_valid & out_ready: out_valid=0 next cycle, state IDLE.
//   - out_data/out_index/out_len/out_trunc retain their last values after the handshake.
//  Throughput: 1 element per (1+L) cycles after the first; exactly 1 min op in flight.
//  Truncation: elements after a forced end belong to the next frame.
//  Stray min out_valid outside WAIT is ignored.
//  Reset mid-frame: partial frame and any in-flight min result are discarded; no output.
// TESTING (half precision: 1.0=3C00, 2.0=4000, 0.5=3800, -1.0=BC00)
//  T1: frame [4000,3C00,3800(last)] -> out_data=3800, out_index=2, out_len=3, out_trunc=0.
//  T2: single [BC00(last)] -> out_data=BC00, index 0, len 1; min in_valid never pulses.
//  T3: ties [3C00,3C00,3C00(last)] -> index 0; then [BC00,3800(last)] -> BC00, index 0.
//  T4: hold out_ready=0 10 cycles in DONE -> outputs stable, in_ready=0;
//      release -> out_valid drops next cycle, next frame accepted.
//  T5: MAX_LEN=4, feed 6 elements [4000,4000,3800,4000,BC00,3C00(last)], no last in the first 4
//      -> result 3800/index 2/len 4/trunc=1; next result BC00/index 0/len 2/trunc=0.
//  T6: rstn low while in WAIT -> outputs 0 immediately;
//      after release, frame [3C00(last)] -> 3C00, index 0, len 1.

Source files
------------

// File: rtl/argmin_reduce.sv
// rtl/argmin_reduce.sv - streaming arg-min reducer with a pipelined floating-point min stage

// Two-cycle floating-point minimum of two operands.
// b_min is set only when b is strictly less than a. NaN on either side, and
// comparisons of +0 against -0, keep a.
module argmin_fp_min #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF"
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            out_valid,
    output logic [BITS-1:0] c,
    output logic            b_min
);
    localparam int EXP_W = (PRECISION == "SINGLE") ? 8 : 5;
    localparam int MAN_W = BITS - 1 - EXP_W;

    logic            sign_a;
    logic            sign_b;
    logic [BITS-2:0] mag_a;
    logic [BITS-2:0] mag_b;
    logic            nan_a;
    logic            nan_b;
    logic            both_zero;
    logic            b_lt_a;

    logic            v_s1;
    logic            v_s2;
    logic [BITS-1:0] c_s1;
    logic [BITS-1:0] c_s2;
    logic            bm_s1;
    logic            bm_s2;

    assign sign_a    = a[BITS-1];
    assign sign_b    = b[BITS-1];
    assign mag_a     = a[BITS-2:0];
    assign mag_b     = b[BITS-2:0];
    assign nan_a     = (&a[BITS-2 -: EXP_W]) && (|a[MAN_W-1:0]);
    assign nan_b     = (&b[BITS-2 -: EXP_W]) && (|b[MAN_W-1:0]);
    assign both_zero = (mag_a == '0) && (mag_b == '0);

    // Sign-magnitude ordering: negative magnitudes compare in reverse.
    always_comb begin
        b_lt_a = 1'b0;
        if (!(nan_a || nan_b || both_zero)) begin
            case ({sign_a, sign_b})
                2'b00:   b_lt_a = (mag_b < mag_a);
                2'b01:   b_lt_a = 1'b1;
                2'b10:   b_lt_a = 1'b0;
                default: b_lt_a = (mag_b > mag_a);
            endcase
        end
    end

    // Two register stages so the reducer sees a real multi-cycle latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_s1  <= 1'b0;
            v_s2  <= 1'b0;
            c_s1  <= '0;
            c_s2  <= '0;
            bm_s1 <= 1'b0;
            bm_s2 <= 1'b0;
        end else begin
            v_s1  <= in_valid;
            c_s1  <= b_lt_a ? b : a;
            bm_s1 <= b_lt_a;
            v_s2  <= v_s1;
            c_s2  <= c_s1;
            bm_s2 <= bm_s1;
        end
    end

    assign out_valid = v_s2;
    assign c         = c_s2;
    assign b_min     = bm_s2;
endmodule

// Arg-min over one last-tagged frame; one min operation in flight at a time.
module argmin_reduce #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF",
    parameter int    MAX_LEN   = 256,
    parameter int    IDX_W     = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_data,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W:0]   out_len,
    output logic             out_trunc
);
    localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(MAX_LEN - 1);
    localparam logic [IDX_W:0] ONE_CNT  = (IDX_W+1)'(1);
    localparam logic           LEN_ONE  = (MAX_LEN == 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [IDX_W:0]   cnt;
    logic [BITS-1:0]  cur_min;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] pend_idx;
    logic             pend_last;
    logic             trunc_q;

    logic             min_in_valid;
    logic             min_out_valid;
    logic [BITS-1:0]  min_c;
    logic             min_b_min;

    logic             accept;
    logic             hit_max;

    assign accept  = in_valid && in_ready;
    assign hit_max = (cnt == LAST_CNT);

    argmin_fp_min #(
        .BITS      (BITS),
        .PRECISION (PRECISION)
    ) u_min (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (min_in_valid),
        .a         (cur_min),
        .b         (in_data),
        .out_valid (min_out_valid),
        .c         (min_c),
        .b_min     (min_b_min)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, input handshake and min issue; min results outside WAIT are ignored.
    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        min_in_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (in_last || LEN_ONE) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    min_in_valid = 1'b1;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                if (min_out_valid) begin
                    state_next = pend_last ? DONE : ACCUM;
                end
            end
            default: begin
                if (out_valid && out_ready) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Running minimum, element count and pending-result bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            cur_min   <= '0;
            cur_idx   <= '0;
            pend_idx  <= '0;
            pend_last <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_min <= in_data;
                        cur_idx <= '0;
                        cnt     <= ONE_CNT;
                        trunc_q <= LEN_ONE && !in_last;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        pend_idx  <= cnt[IDX_W-1:0];
                        pend_last <= in_last || hit_max;
                        trunc_q   <= hit_max && !in_last;
                        cnt       <= cnt + ONE_CNT;
                    end
                end
                WAIT: begin
                    if (min_out_valid && min_b_min) begin
                        cur_min <= min_c;
                        cur_idx <= pend_idx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: loaded while in DONE, held after the handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_len   <= '0;
            out_trunc <= 1'b0;
        end else if (state == DONE) begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end else if (!out_valid) begin
                out_valid <= 1'b1;
                out_data  <= cur_min;
                out_index <= cur_idx;
                out_len   <= cnt;
                out_trunc <= trunc_q;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_argmin_reduce.sv
// tb/tb_argmin_reduce.sv - self-checking bench for argmin_reduce
`timescale 1ns/1ps
module tb_argmin_reduce;
    localparam int MAX_LEN = 4;
    localparam int IDX_W   = 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_data;
    logic [IDX_W-1:0] out_index;
    logic [IDX_W:0]   out_len;
    logic             out_trunc;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] d;
        int          idx;
        int          len;
        bit          trunc;
    } res_t;

    logic [15:0] frame[$];
    res_t        expq[$];
    bit          count_pulses = 1'b0;
    int          min_pulses = 0;

    always #5 clk = ~clk;

    argmin_reduce #(
        .BITS      (16),
        .PRECISION ("HALF"),
        .MAX_LEN   (MAX_LEN)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_len   (out_len),
        .out_trunc (out_trunc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic real h2r(input logic [15:0] h);
        int  e = int'(h[14:10]);
        int  p;
        real v;
        v = (e == 0) ? real'(h[9:0]) / 1024.0 : 1.0 + real'(h[9:0]) / 1024.0;
        p = (e == 0) ? -14 : e - 15;
        while (p > 0) begin v = v * 2.0; p--; end
        while (p < 0) begin v = v / 2.0; p++; end
        return h[15] ? -v : v;
    endfunction

    function automatic res_t reduce_frame();
        res_t r;
        r.idx = 0;
        for (int i = 1; i < frame.size(); i++) begin
            if (h2r(frame[i]) < h2r(frame[r.idx])) r.idx = i;
        end
        r.d   = frame[r.idx];
        r.len = frame.size();
        return r;
    endfunction

    // Reference model and per-cycle comparison of every presented result.
    always @(negedge clk) begin
        res_t r;
        if (!rstn) begin
            frame.delete();
            expq.delete();
        end else begin
            if (count_pulses && u_dut.min_in_valid) min_pulses++;
            if (in_valid && in_ready) begin
                frame.push_back(in_data);
                if (in_last || frame.size() == MAX_LEN) begin
                    r = reduce_frame();
                    r.trunc = !in_last;
                    expq.push_back(r);
                    frame.delete();
                end
            end
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    r = expq[0];
                    chk("model_result",
                        {3'b0, out_data, 6'(out_index), 6'(out_len), out_trunc},
                        {3'b0, r.d, 6'(r.idx), 6'(r.len), r.trunc});
                    chk("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (out_ready) void'(expq.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic expect_res(input string name, input logic [15:0] d, input int idx,
                              input int len, input bit trunc);
        wait_valid();
        chk({name, "_data"}, 32'(out_data), 32'(d));
        chk({name, "_index"}, 32'(out_index), 32'(idx));
        chk({name, "_len"}, 32'(out_len), 32'(len));
        chk({name, "_trunc"}, 32'(out_trunc), 32'(trunc));
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", {3'b0, out_data, 6'(out_index), 6'(out_len), out_trunc}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // T1: plain frame, minimum in last position.
        min_pulses = 0; count_pulses = 1'b1;
        send(16'h4000, 1'b0);
        send(16'h3C00, 1'b0);
        send(16'h3800, 1'b1);
        expect_res("t1", 16'h3800, 2, 3, 1'b0);
        count_pulses = 1'b0;
        chk("t1_min_pulses", 32'(min_pulses), 32'd2);

        // T2: single element never invokes min.
        min_pulses = 0; count_pulses = 1'b1;
        send(16'hBC00, 1'b1);
        expect_res("t2", 16'hBC00, 0, 1, 1'b0);
        count_pulses = 1'b0;
        chk("t2_min_pulses", 32'(min_pulses), 32'd0);

        // T3: ties keep the earliest index.
        send(16'h3C00, 1'b0);
        send(16'h3C00, 1'b0);
        send(16'h3C00, 1'b1);
        expect_res("t3a", 16'h3C00, 0, 3, 1'b0);
        send(16'hBC00, 1'b0);
        send(16'h3800, 1'b1);
        expect_res("t3b", 16'hBC00, 0, 2, 1'b0);

        // T4: backpressure in DONE.
        send(16'h4000, 1'b1);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_data", 32'(out_data), 32'h4000);
            chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("t4_valid_drop", 32'(out_valid), 32'd0);
        chk("t4_retain_data", 32'(out_data), 32'h4000);
        @(posedge clk);
        #1;
        send(16'h3800, 1'b1);
        expect_res("t4_next", 16'h3800, 0, 1, 1'b0);

        // T5: forced end at MAX_LEN, remainder forms the next frame.
        fork
            begin
                send(16'h4000, 1'b0);
                send(16'h4000, 1'b0);
                send(16'h3800, 1'b0);
                send(16'h4000, 1'b0);
                send(16'hBC00, 1'b0);
                send(16'h3C00, 1'b1);
            end
            begin
                expect_res("t5a", 16'h3800, 2, 4, 1'b1);
                expect_res("t5b", 16'hBC00, 0, 2, 1'b0);
            end
        join

        // T6: reset while a min result is in flight.
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_outputs", {3'b0, out_data, 6'(out_index), 6'(out_len), out_trunc}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t6_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h3C00, 1'b1);
        expect_res("t6", 16'h3C00, 0, 1, 1'b0);

        repeat (5) @(posedge clk);
        chk("model_drained", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
